// File: rtl/add_sched_pkg.sv
// Shared defaults, requester-ID width derivation and the result record for the
// add_sched arbitrated adder.
package add_sched_pkg;

    localparam int W_DEFAULT   = 8;
    localparam int N_DEFAULT   = 2;
    localparam int N_MIN       = 2;
    localparam int N_MAX       = 4;
    localparam int CARRY_CNT_W = 8;

    localparam logic [CARRY_CNT_W-1:0] CARRY_CNT_MAX = '1;

    // Requester-ID width; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW_DEFAULT = idw_of(N_DEFAULT);

    // Result record for the default configuration.
    typedef struct packed {
        logic [W_DEFAULT-1:0]   sum;
        logic                   carry;
        logic [IDW_DEFAULT-1:0] id;
    } res_t;

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted requester;
// the pointer moves only when the granted request is actually accepted.
module rr_arbiter
    import add_sched_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = idw_of(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    input  logic           accept,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] last_grant_reg;
    logic [IDW-1:0] last_grant_next;
    logic           found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_grant_reg) + k) % N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // Decode the winning index; the enable gates every grant line so nothing
    // is offered while the consumer cannot take it.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = en && found && (grant_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        last_grant_next = last_grant_reg;
        if (accept) begin
            last_grant_next = grant_idx;
        end
    end

    // Reset parks the pointer on the last requester so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= IDW'(N - 1);
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/add_sched.sv
// Arbitrated adder: N requesters share one W-bit adder feeding a single-entry
// valid/ready result register, plus a saturating count of carry-out results.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int N   = N_DEFAULT,
    parameter int IDW = idw_of(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*W-1:0]         req_a,
    input  logic [N*W-1:0]         req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [W-1:0]           res_sum,
    output logic                   res_carry,
    output logic [IDW-1:0]         res_id,
    output logic [CARRY_CNT_W-1:0] carry_cnt
);

    typedef struct packed {
        logic [W-1:0]   sum;
        logic           carry;
        logic [IDW-1:0] id;
    } res_reg_t;

    res_reg_t               res_reg;
    res_reg_t               res_next;
    logic                   res_valid_reg;
    logic                   res_valid_next;
    logic [CARRY_CNT_W-1:0] carry_cnt_reg;
    logic [CARRY_CNT_W-1:0] carry_cnt_next;

    logic                   can_accept;
    logic                   arb_en;
    logic [N-1:0]           grant;
    logic [IDW-1:0]         grant_idx;
    logic                   transfer;
    logic [W-1:0]           a_sel;
    logic [W-1:0]           b_sel;
    logic [W:0]             sum_full;

    // Handshake depends only on valid bits and result-register state, never on
    // operand values.
    assign can_accept = !res_valid_reg || res_ready;
    assign arb_en     = can_accept && !rst;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (arb_en),
        .accept    (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        res_next       = res_reg;
        res_valid_next = res_valid_reg;
        carry_cnt_next = carry_cnt_reg;
        if (transfer) begin
            res_next.sum   = sum_full[W-1:0];
            res_next.carry = sum_full[W];
            res_next.id    = grant_idx;
            res_valid_next = 1'b1;
            if (sum_full[W] && (carry_cnt_reg != CARRY_CNT_MAX)) begin
                carry_cnt_next = carry_cnt_reg + 1'b1;
            end
        end else if (res_ready) begin
            // Drain without refill: data fields keep their last value.
            res_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
            carry_cnt_reg <= '0;
        end else begin
            res_reg       <= res_next;
            res_valid_reg <= res_valid_next;
            carry_cnt_reg <= carry_cnt_next;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_sum   = res_reg.sum;
    assign res_carry = res_reg.carry;
    assign res_id    = res_reg.id;
    assign carry_cnt = carry_cnt_reg;

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched (W=8, N=2): reset, add/carry, round-robin,
// backpressure, counter saturation, mid-operation reset and idle behaviour.
module tb_add_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_sum;
    logic        res_carry;
    logic [0:0]  res_id;
    logic [7:0]  carry_cnt;

    int checks;
    int failures;

    add_sched #(.W(8), .N(2), .IDW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id),
        .carry_cnt (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
        req_a = 16'h5555; req_b = 16'h2222;
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready_in_rst got=%b exp=00", req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00; #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_sum !== 8'h00) begin failures++; $display("FAIL reset_res_sum got=%h exp=00", res_sum); end
        checks++; if (res_carry !== 1'b0) begin failures++; $display("FAIL reset_res_carry got=%b exp=0", res_carry); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL reset_res_id got=%h exp=0", res_id); end
        checks++; if (carry_cnt !== 8'd0) begin failures++; $display("FAIL reset_carry_cnt got=%0d exp=0", carry_cnt); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_basic();
        @(negedge clk);
        req_valid = 2'b01; req_a = 16'h0012; req_b = 16'h0034; res_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL basic_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", res_valid); end
        checks++; if (res_sum !== 8'h46) begin failures++; $display("FAIL basic_sum got=%h exp=46", res_sum); end
        checks++; if (res_carry !== 1'b0) begin failures++; $display("FAIL basic_carry got=%b exp=0", res_carry); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL basic_id got=%h exp=0", res_id); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL basic_idle_ready got=%b exp=00", req_ready); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_drain_valid got=%b exp=0", res_valid); end
        checks++; if (res_sum !== 8'h46) begin failures++; $display("FAIL basic_drain_sum_hold got=%h exp=46", res_sum); end
        $display("test_basic done 12+34 -> 46");
    endtask

    task automatic test_carry();
        @(negedge clk);
        req_valid = 2'b01; req_a = 16'h00FF; req_b = 16'h0002; res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++; if (res_sum !== 8'h01) begin failures++; $display("FAIL carry_sum got=%h exp=01", res_sum); end
        checks++; if (res_carry !== 1'b1) begin failures++; $display("FAIL carry_bit got=%b exp=1", res_carry); end
        checks++; if (carry_cnt !== 8'd1) begin failures++; $display("FAIL carry_cnt got=%0d exp=1", carry_cnt); end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        $display("test_carry done FF+02 -> 01 c=1");
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready;
        logic [7:0] exp_sum;
        do_reset();
        req_valid = 2'b11; req_a = 16'h2010; req_b = 16'h0201; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_sum   = (i % 2 == 0) ? 8'h11 : 8'h22;
            #1;
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready); end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, res_valid); end
            checks++; if (res_id !== 1'(i % 2)) begin failures++; $display("FAIL rr_id[%0d] got=%h exp=%0d", i, res_id, i % 2); end
            checks++; if (res_sum !== exp_sum) begin failures++; $display("FAIL rr_sum[%0d] got=%h exp=%h", i, res_sum, exp_sum); end
            $display("rr op %0d id=%0d sum=%h", i, res_id, res_sum);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        res_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=00", j, req_ready); end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", j, res_valid); end
            checks++; if (res_sum !== 8'h22) begin failures++; $display("FAIL bp_sum[%0d] got=%h exp=22", j, res_sum); end
            checks++; if (res_id !== 1'b1) begin failures++; $display("FAIL bp_id[%0d] got=%h exp=1", j, res_id); end
            @(negedge clk);
        end
        res_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_release_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", res_valid); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL bp_release_id got=%h exp=0", res_id); end
        checks++; if (res_sum !== 8'h11) begin failures++; $display("FAIL bp_release_sum got=%h exp=11", res_sum); end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", res_valid); end
        @(negedge clk);
        $display("test_back_to_back_backpressure done");
    endtask

    task automatic test_saturate();
        req_valid = 2'b01; req_a = 16'h0080; req_b = 16'h0080; res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (i == 253) begin
                checks++; if (carry_cnt !== 8'd254) begin failures++; $display("FAIL sat_cnt_254 got=%0d exp=254", carry_cnt); end
            end
            if (i == 254) begin
                checks++; if (carry_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt_255 got=%0d exp=255", carry_cnt); end
            end
        end
        checks++; if (carry_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt_hold got=%0d exp=255", carry_cnt); end
        checks++; if (res_sum !== 8'h00) begin failures++; $display("FAIL sat_sum got=%h exp=00", res_sum); end
        checks++; if (res_carry !== 1'b1) begin failures++; $display("FAIL sat_carry got=%b exp=1", res_carry); end
        @(negedge clk);
        $display("test_saturate done cnt=%0d", carry_cnt);
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b11; res_ready = 1'b0; #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_pre_ready got=%b exp=00", req_ready); end
        rst = 1'b1; res_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_rst_ready got=%b exp=00", req_ready); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", res_valid); end
        checks++; if (carry_cnt !== 8'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", carry_cnt); end
        @(negedge clk);
        rst = 1'b0; req_a = 16'h2010; req_b = 16'h0201; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL mid_first_id got=%h exp=0", res_id); end
        checks++; if (res_sum !== 8'h11) begin failures++; $display("FAIL mid_first_sum got=%h exp=11", res_sum); end
        checks++; if (carry_cnt !== 8'd0) begin failures++; $display("FAIL mid_first_cnt got=%0d exp=0", carry_cnt); end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    task automatic test_idle();
        req_valid = 2'b00; res_ready = 1'b0; req_a = 16'hFFFF; req_b = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL idle_ready[%0d] got=%b exp=00", i, req_ready); end
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, res_valid); end
            checks++; if (res_sum !== 8'h11) begin failures++; $display("FAIL idle_sum_hold[%0d] got=%h exp=11", i, res_sum); end
            checks++; if (carry_cnt !== 8'd0) begin failures++; $display("FAIL idle_cnt[%0d] got=%0d exp=0", i, carry_cnt); end
            @(negedge clk);
        end
        $display("test_idle done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_back_to_back_backpressure();
        test_saturate();
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
